// File: rtl/vsrc_pkg.sv
// ---------------------------------------------------------------------------
// vsrc_pkg
// Shared definitions for the video source switch:
//   vsrcState_e : switch FSM states (RUN, DRAIN, BLANK)
//   selWidth()  : width of a channel-select field for a given channel count
// ---------------------------------------------------------------------------
package vsrc_pkg;

  // RUN   : full pass-through of the current channel
  // DRAIN : still showing the old channel, waiting for its frame to end
  // BLANK : new channel selected, picture blanked until its frame starts
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    BLANK = 2'd2
  } vsrcState_e;

  // Select width is clog2 of the channel count, never narrower than one bit
  function automatic int selWidth(input int numCh);
    return (numCh <= 2) ? 1 : $clog2(numCh);
  endfunction

endpackage

// File: rtl/vsrc_activity.sv
// ---------------------------------------------------------------------------
// vsrc_activity
// Per-channel vsync rising-edge detector and optional activity timeout.
// Build option: VIDEO_SRC_SWITCH_TIMEOUT_EN adds a saturating counter that
// flags the channel inactive after TO_CYC cycles without a vsync rise;
// without it the channel always reads as active once out of reset.
// Ports:
//   clk      in  pixel clock
//   reset_n  in  synchronous active-low reset
//   vs_i     in  channel vsync
//   vsRise_o out vsync rising edge this cycle (combinational)
//   active_o out channel has shown a vsync rise within TO_CYC cycles
// ---------------------------------------------------------------------------
module vsrc_activity #(
  parameter int unsigned TO_CYC = 2**22
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vs_i,
  output logic vsRise_o,
  output logic active_o
);

  logic vsDly_q;
  logic active_q;

  assign vsRise_o = vs_i & ~vsDly_q;
  assign active_o = active_q;

  // One-cycle delayed copy of vsync for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) vsDly_q <= 1'b0;
    else          vsDly_q <= vs_i;
  end

`ifdef VIDEO_SRC_SWITCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TO_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_CYC);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count cycles since the last vsync rise, holding at the timeout value
  always_comb begin
    cnt_d = cnt_q;
    if (vsRise_o)              cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // The activity flag is registered off the next count so it tracks the
  // counter exactly while still reading zero during reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= (cnt_d < CNT_MAX);
    end
  end
`else
  // No timeout: every channel is considered active outside reset
  always_ff @(posedge clk) begin
    if (!reset_n) active_q <= 1'b0;
    else          active_q <= 1'b1;
  end
`endif

endmodule

// File: rtl/video_src_switch.sv
// ---------------------------------------------------------------------------
// video_src_switch
// Frame-aligned switch between NUM_CH synchronous video sources. A request
// waits for the current frame to end (DRAIN), then blanks the picture on the
// new channel until its first frame starts (BLANK), then passes it through.
// Build option: VIDEO_SRC_SWITCH_TIMEOUT_EN lets DRAIN/BLANK give up on a
// channel whose vsync has gone quiet for TO_CYC cycles.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   in_de/in_hs/in_vs [NUM_CH]   per-channel timing, bit i = channel i
//   in_rgb [NUM_CH*3*CW]         per-channel {R,G,B}
//   sel_req, sel_vld             requested channel and its strobe
//   sel_cur                      channel currently driving the output
//   busy                         switch pending
//   sel_err                      one-cycle pulse on an out-of-range request
//   ch_active [NUM_CH]           per-channel vsync activity
//   out_de/hs/vs, out_r/g/b      registered selected video
// ---------------------------------------------------------------------------
module video_src_switch
  import vsrc_pkg::*;
#(
  parameter  int NUM_CH = 2,
  parameter  int CW     = 12,
  parameter  int DEF_CH = 0,
  parameter  int TO_CYC = 2**22,
  localparam int SEL_W  = selWidth(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_CH-1:0]      in_de,
  input  logic [NUM_CH-1:0]      in_hs,
  input  logic [NUM_CH-1:0]      in_vs,
  input  logic [NUM_CH*3*CW-1:0] in_rgb,
  input  logic [SEL_W-1:0]       sel_req,
  input  logic                   sel_vld,
  output logic [SEL_W-1:0]       sel_cur,
  output logic                   busy,
  output logic                   sel_err,
  output logic [NUM_CH-1:0]      ch_active,
  output logic                   out_de,
  output logic                   out_hs,
  output logic                   out_vs,
  output logic [CW-1:0]          out_r,
  output logic [CW-1:0]          out_g,
  output logic [CW-1:0]          out_b
);

  localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(DEF_CH);
  localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);

  vsrcState_e       state_q, state_d, edgeState;
  logic [SEL_W-1:0] selCur_q, selCur_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic             hold_q, hold_d;
  logic             err_q;
  logic             reqValid, reqBad, curIdle, blank;
  logic [NUM_CH-1:0] vsRise;
  logic [NUM_CH-1:0] chActive;
  logic [3*CW-1:0]  chRgb [NUM_CH];
  logic             outDe_q, outHs_q, outVs_q;
  logic [3*CW-1:0]  outRgb_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : gChan
    assign chRgb[g] = in_rgb[g*3*CW +: 3*CW];

    vsrc_activity #(.TO_CYC(TO_CYC)) uActivity (
      .clk      (clk),
      .reset_n  (reset_n),
      .vs_i     (in_vs[g]),
      .vsRise_o (vsRise[g]),
      .active_o (chActive[g])
    );
  end

`ifdef VIDEO_SRC_SWITCH_TIMEOUT_EN
  assign curIdle = ~chActive[selCur_q];
`else
  assign curIdle = 1'b0;
`endif

  // State register: FSM state, current/pending channel, blank hold, error
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= RUN;
      selCur_q <= DEF_SEL;
      target_q <= DEF_SEL;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      selCur_q <= selCur_d;
      target_q <= target_d;
      hold_q   <= hold_d;
      err_q    <= reqBad;
    end
  end

  // Next state: vsync/timeout events act on the registered state first, and a
  // same-cycle request is then applied on top of that result
  always_comb begin
    state_d   = state_q;
    selCur_d  = selCur_q;
    target_d  = target_q;
    hold_d    = hold_q;
    edgeState = state_q;
    reqValid  = sel_vld && ({1'b0, sel_req} < NUM_CH_W);
    reqBad    = sel_vld && !reqValid;

    // A timed-out channel keeps the picture blanked until its first frame
    if (vsRise[selCur_q]) hold_d = 1'b0;

    case (state_q)
      DRAIN: begin
        if (vsRise[selCur_q] || curIdle) begin
          selCur_d  = target_q;
          edgeState = BLANK;
        end
      end
      BLANK: begin
        if (vsRise[selCur_q]) begin
          edgeState = RUN;
        end else if (curIdle) begin
          edgeState = RUN;
          hold_d    = 1'b1;
        end
      end
      default: ;
    endcase

    state_d = edgeState;
    if (reqValid) begin
      case (edgeState)
        RUN: begin
          if (sel_req != selCur_d) begin
            target_d = sel_req;
            state_d  = DRAIN;
          end
        end
        DRAIN: target_d = sel_req;
        BLANK: begin
          if (sel_req == selCur_d) begin
            state_d = RUN;
          end else begin
            target_d = sel_req;
            selCur_d = sel_req;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from the registered state
  always_comb begin
    busy  = (state_q != RUN);
    blank = (state_q == BLANK) || hold_q;
  end

  // Registered video path; sync always follows the selected channel while
  // data enable and colour are forced low during blanking
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      outDe_q  <= 1'b0;
      outHs_q  <= 1'b0;
      outVs_q  <= 1'b0;
      outRgb_q <= '0;
    end else begin
      outDe_q  <= blank ? 1'b0 : in_de[selCur_q];
      outHs_q  <= in_hs[selCur_q];
      outVs_q  <= in_vs[selCur_q];
      outRgb_q <= blank ? '0 : chRgb[selCur_q];
    end
  end

  assign sel_cur   = selCur_q;
  assign sel_err   = err_q;
  assign ch_active = chActive;
  assign out_de    = outDe_q;
  assign out_hs    = outHs_q;
  assign out_vs    = outVs_q;
  assign out_r     = outRgb_q[3*CW-1:2*CW];
  assign out_g     = outRgb_q[2*CW-1:CW];
  assign out_b     = outRgb_q[CW-1:0];

endmodule

// File: tb/tb_video_src_switch.sv
// ---------------------------------------------------------------------------
// tb_video_src_switch
// Directed bench for video_src_switch. Five channels are used so that
// out-of-range request codes fit on the 3-bit select port. The activity
// timeout scenario is compiled in with VIDEO_SRC_SWITCH_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_video_src_switch;

  localparam int NCH = 5;
  localparam int CW  = 4;

  logic             clk;
  logic             reset_n;
  logic [NCH-1:0]   in_de, in_hs, in_vs;
  logic [NCH*3*CW-1:0] in_rgb;
  logic [2:0]       sel_req;
  logic             sel_vld;
  logic [2:0]       sel_cur;
  logic             busy, sel_err;
  logic [NCH-1:0]   ch_active;
  logic             out_de, out_hs, out_vs;
  logic [CW-1:0]    out_r, out_g, out_b;

  int assertCount = 0;
  int failCount   = 0;

  video_src_switch #(
    .NUM_CH (NCH),
    .CW     (CW),
    .DEF_CH (0),
    .TO_CYC (1000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_de     (in_de),
    .in_hs     (in_hs),
    .in_vs     (in_vs),
    .in_rgb    (in_rgb),
    .sel_req   (sel_req),
    .sel_vld   (sel_vld),
    .sel_cur   (sel_cur),
    .busy      (busy),
    .sel_err   (sel_err),
    .ch_active (ch_active),
    .out_de    (out_de),
    .out_hs    (out_hs),
    .out_vs    (out_vs),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b)
  );

  // Free-running pixel clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct constant colour per channel
  function automatic logic [11:0] chanRgb(input int c);
    logic [3:0] r, g, b;
    r = 4'(c + 1);
    g = 4'(c + 6);
    b = 4'(c + 10);
    return {r, g, b};
  endfunction

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance n clock edges and settle just after the last one
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // One-cycle request strobe
  task automatic applyStimulus(input logic [2:0] req);
    sel_req = req;
    sel_vld = 1'b1;
    step(1);
    sel_vld = 1'b0;
  endtask

  // One-cycle vsync pulse on a channel
  task automatic pulseVs(input int ch);
    in_vs[ch] = 1'b1;
    step(1);
    in_vs[ch] = 1'b0;
  endtask

  task automatic checkVideo(input string tag, input int ch, input bit blanked);
    if (blanked) begin
      checkOutput({tag, "_de"}, 32'(out_de), 32'd0);
      checkOutput({tag, "_rgb"}, 32'({out_r, out_g, out_b}), 32'd0);
    end else begin
      checkOutput({tag, "_de"}, 32'(out_de), 32'd1);
      checkOutput({tag, "_rgb"}, 32'({out_r, out_g, out_b}), 32'(chanRgb(ch)));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    in_de   = '1;
    in_hs   = '0;
    in_vs   = '0;
    sel_req = '0;
    sel_vld = 1'b0;
    for (int i = 0; i < NCH; i++) in_rgb[i*12 +: 12] = chanRgb(i);

    // Reset state
    step(3);
    checkOutput("rst_cur", 32'(sel_cur), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err", 32'(sel_err), 32'd0);
    checkOutput("rst_act", 32'(ch_active), 32'd0);
    checkOutput("rst_sync", 32'({out_hs, out_vs}), 32'd0);
    checkVideo("rst", 0, 1'b1);

    // Channel 0 one cycle after release
    reset_n = 1'b1;
    step(1);
    checkVideo("pass0", 0, 1'b0);
    checkOutput("act_all", 32'(ch_active), 32'h1F);

    // Switch 0 -> 2
    applyStimulus(3'd2);
    checkOutput("sw2_busy", 32'(busy), 32'd1);
    step(3);
    checkVideo("drain0", 0, 1'b0);
    checkOutput("drain_cur", 32'(sel_cur), 32'd0);
    pulseVs(0);
    checkOutput("drain_vs", 32'(out_vs), 32'd1);
    checkVideo("drain_last", 0, 1'b0);
    checkOutput("blank_cur", 32'(sel_cur), 32'd2);
    in_hs[2] = 1'b1;
    step(1);
    in_hs[2] = 1'b0;
    checkVideo("blank2", 2, 1'b1);
    checkOutput("blank_hs", 32'(out_hs), 32'd1);
    checkOutput("blank_busy", 32'(busy), 32'd1);
    pulseVs(2);
    checkOutput("run2_busy", 32'(busy), 32'd0);
    checkOutput("blank_vs", 32'(out_vs), 32'd1);
    checkVideo("blank_last", 2, 1'b1);
    step(1);
    checkVideo("pass2", 2, 1'b0);

    // Out-of-range and same-channel requests
    applyStimulus(3'd5);
    checkOutput("err_pulse", 32'(sel_err), 32'd1);
    checkOutput("err_cur", 32'(sel_cur), 32'd2);
    checkOutput("err_busy", 32'(busy), 32'd0);
    step(1);
    checkOutput("err_clear", 32'(sel_err), 32'd0);
    applyStimulus(3'd2);
    checkOutput("same_busy", 32'(busy), 32'd0);
    checkOutput("same_err", 32'(sel_err), 32'd0);

    // Retarget during DRAIN: 1 then 3, channel 1 never shown
    applyStimulus(3'd1);
    applyStimulus(3'd3);
    checkOutput("retgt_busy", 32'(busy), 32'd1);
    checkOutput("retgt_cur", 32'(sel_cur), 32'd2);
    pulseVs(2);
    checkOutput("retgt_new", 32'(sel_cur), 32'd3);
    pulseVs(1);
    checkOutput("retgt_wait", 32'(busy), 32'd1);
    checkVideo("retgt_blank", 3, 1'b1);
    pulseVs(3);
    checkOutput("retgt_done", 32'(busy), 32'd0);
    step(1);
    checkVideo("pass3", 3, 1'b0);
    checkOutput("pass3_cur", 32'(sel_cur), 32'd3);

    // Request for the BLANK channel itself ends the switch at once
    applyStimulus(3'd4);
    pulseVs(3);
    checkOutput("b2r_cur", 32'(sel_cur), 32'd4);
    applyStimulus(3'd4);
    checkOutput("b2r_busy", 32'(busy), 32'd0);
    step(1);
    checkVideo("pass4", 4, 1'b0);

    // vsync edge and new request in the same cycle
    applyStimulus(3'd0);
    in_vs[4] = 1'b1;
    applyStimulus(3'd1);
    in_vs[4] = 1'b0;
    checkOutput("coin_cur", 32'(sel_cur), 32'd1);
    checkOutput("coin_busy", 32'(busy), 32'd1);
    pulseVs(1);
    checkOutput("coin_done", 32'(busy), 32'd0);
    step(1);
    checkVideo("pass1", 1, 1'b0);

    // Reset during BLANK abandons the switch
    applyStimulus(3'd3);
    pulseVs(1);
    checkOutput("pre_rst_cur", 32'(sel_cur), 32'd3);
    reset_n = 1'b0;
    step(1);
    checkOutput("mrst_cur", 32'(sel_cur), 32'd0);
    checkOutput("mrst_busy", 32'(busy), 32'd0);
    checkVideo("mrst", 0, 1'b1);
    reset_n = 1'b1;
    step(1);
    checkVideo("post_rst", 0, 1'b0);
    pulseVs(3);
    checkOutput("post_rst_cur", 32'(sel_cur), 32'd0);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);

`ifdef VIDEO_SRC_SWITCH_TIMEOUT_EN
    // All channels quiet past the timeout
    step(1005);
    checkOutput("to_inactive", 32'(ch_active), 32'd0);
    applyStimulus(3'd1);
    checkOutput("to_drain_cur", 32'(sel_cur), 32'd0);
    checkOutput("to_drain_busy", 32'(busy), 32'd1);
    step(1);
    checkOutput("to_exit_drain", 32'(sel_cur), 32'd1);
    step(1);
    checkOutput("to_exit_blank", 32'(busy), 32'd0);
    step(1);
    checkVideo("to_hold", 1, 1'b1);
    pulseVs(1);
    checkOutput("to_act1", 32'(ch_active), 32'h02);
    checkVideo("to_hold_last", 1, 1'b1);
    step(1);
    checkVideo("to_pass1", 1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
